// File: rtl/count_up_stopwatch_pkg.sv
// Shared types and constants for the HH:MM:SS.cc count-up stopwatch.
package count_up_stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] DIGIT_MAX9 = 4'd9;
    localparam logic [3:0] DIGIT_MAX5 = 4'd5;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
        logic [7:0] cc;
    } bcd_time_t;

    function automatic logic [7:0] to_bcd8(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/count_up_stopwatch_bcd_digit_counter.sv
// One BCD digit 0..MAX; carry_o pulses on the increment that wraps MAX back to 0.
module count_up_stopwatch_bcd_digit_counter #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_i,
    input  logic       clr_i,
    output logic [3:0] digit_o,
    output logic       carry_o
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    // NOTE: default assignment first so no path leaves digit_d unassigned (no latch).
    always_comb begin
        digit_d = digit_q;
        if (clr_i) begin
            digit_d = '0;
        end else if (inc_i) begin
            digit_d = (digit_q == MAX) ? 4'd0 : digit_q + 4'd1;
        end
    end

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;
    assign carry_o = inc_i && !clr_i && (digit_q == MAX);

endmodule

// File: rtl/count_up_stopwatch.sv
// Elapsed-time stopwatch: FSM, tick prescaler, 8-digit BCD chain, lap latch and
// registered display outputs that saturate at MAX_HOUR:59:59.99.
module count_up_stopwatch
    import count_up_stopwatch_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 100,
    parameter int MAX_HOUR = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       play,
    input  logic       stop,
    input  logic       clear,
    input  logic       lap,
    output logic [7:0] hour_out_bcd,
    output logic [7:0] minute_out_bcd,
    output logic [7:0] second_out_bcd,
    output logic [7:0] centi_out_bcd,
    output logic       counting,
    output logic       lap_active,
    output logic       overflow
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam bcd_time_t CEILING = {to_bcd8(MAX_HOUR), 8'h59, 8'h59, 8'h99};

    state_e    state_q;
    logic [PW-1:0] presc_q, presc_d;
    bcd_time_t lap_q, out_q, live;
    logic      lap_active_q, overflow_q, counting_q;
    logic      tick, at_ceiling, advance;
    logic [31:0] live_flat;
    logic [7:0]  inc, carry;
    logic        carry_unused;

    assign tick       = (state_q == ST_RUN) && (presc_q == PW'(DIV - 1));
    assign at_ceiling = (live == CEILING);
    assign advance    = tick && !at_ceiling;

    always_comb begin
        presc_d = presc_q;
        if (clear) begin
            presc_d = '0;
        end else if (state_q == ST_RUN) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
    end

    // Digit order, least significant first: cc units/tens, ss, mm, hh.
    assign inc          = {carry[6:0], advance};
    assign carry_unused = carry[7];
    assign live         = live_flat;

    for (genvar i = 0; i < 8; i++) begin : g_digit
        localparam logic [3:0] LIM = (i == 3 || i == 5) ? DIGIT_MAX5 : DIGIT_MAX9;
        count_up_stopwatch_bcd_digit_counter #(.MAX(LIM)) u_digit (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc_i   (inc[i]),
            .clr_i   (clear),
            .digit_o (live_flat[4*i +: 4]),
            .carry_o (carry[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            lap_q        <= '0;
            out_q        <= '0;
            lap_active_q <= 1'b0;
            overflow_q   <= 1'b0;
            counting_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            out_q   <= clear ? '0 : (lap_active_q ? lap_q : live);
            if (clear) begin
                state_q      <= ST_IDLE;
                lap_active_q <= 1'b0;
                overflow_q   <= 1'b0;
                counting_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE, ST_PAUSE: begin
                        if (play) begin
                            state_q    <= ST_RUN;
                            counting_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        // Ceiling tick outranks stop/lap: the count freezes and DONE is final.
                        if (tick && at_ceiling) begin
                            state_q      <= ST_DONE;
                            counting_q   <= 1'b0;
                            overflow_q   <= 1'b1;
                            lap_active_q <= 1'b0;
                        end else if (play) begin
                            state_q <= ST_RUN;
                        end else if (stop) begin
                            state_q    <= ST_PAUSE;
                            counting_q <= 1'b0;
                        end else if (lap) begin
                            lap_active_q <= !lap_active_q;
                            if (!lap_active_q) begin
                                lap_q <= live;
                            end
                        end
                    end
                    ST_DONE: state_q <= ST_DONE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign hour_out_bcd   = out_q.hh;
    assign minute_out_bcd = out_q.mm;
    assign second_out_bcd = out_q.ss;
    assign centi_out_bcd  = out_q.cc;
    assign counting       = counting_q;
    assign lap_active     = lap_active_q;
    assign overflow       = overflow_q;

endmodule
